// File: rtl/pkt_write_seq.sv
// pkt_write_seq: packet write sequencer streaming port words to SRAM with auto-incremented addresses, define PKT_WRITE_PARITY_EN for word parity
module pkt_write_seq #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 12,
  parameter int DES_W     = 4,
  parameter int PRI_W     = 3,
  parameter int LEN_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [PRI_W-1:0]     priority_in,
  input  logic [DES_W-1:0]     des_port_in,
  input  logic [LEN_W-1:0]     pack_len_in,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [NUM_PORTS-1:0] eop,
  input  logic                 busy,
  output logic                 in_ready,
  output logic                 request,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [PRI_W-1:0]     wr_priority,
  output logic [DES_W-1:0]     wr_des,
`ifdef PKT_WRITE_PARITY_EN
  input  logic                 in_parity,
  output logic                 wr_parity,
`endif
  output logic                 done,
  output logic                 len_err
);
  typedef enum logic [1:0] {IDLE, WRITE, DRAIN, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W:0]    cnt, cnt_nx;
  logic              acc, last, at_len, perr;
  always_comb begin
    in_ready = (state == WRITE && !busy) || state == DRAIN;
    acc      = in_valid && in_ready;
    last     = |eop;
    cnt_nx   = cnt + 1'b1;
    at_len   = cnt_nx == {1'b0, len};
`ifdef PKT_WRITE_PARITY_EN
    perr     = acc && ((^in_data) != in_parity);
`else
    perr     = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      len         <= '0;
      cnt         <= '0;
      request     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_priority <= '0;
      wr_des      <= '0;
      done        <= 1'b0;
      len_err     <= 1'b0;
`ifdef PKT_WRITE_PARITY_EN
      wr_parity   <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (perr) len_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          base        <= base_addr;
          len         <= pack_len_in;
          wr_priority <= priority_in;
          wr_des      <= des_port_in;
          cnt         <= '0;
          request     <= 1'b1;
          len_err     <= pack_len_in == '0;
          state       <= pack_len_in == '0 ? DRAIN : WRITE;
        end
        WRITE: if (acc) begin
          wr_en   <= 1'b1;
          wr_addr <= base + ADDR_W'(cnt);
          wr_data <= in_data;
`ifdef PKT_WRITE_PARITY_EN
          wr_parity <= ^in_data;
`endif
          cnt     <= cnt_nx;
          if (last) begin
            if (!at_len) len_err <= 1'b1;
            done    <= 1'b1;
            request <= 1'b0;
            state   <= DONE;
          end else if (at_len) begin
            len_err <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: if (acc && last) begin
          done    <= 1'b1;
          request <= 1'b0;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
